aes_key_sched_ctrl: RTL and testbench
=====================================

AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

Interface
REQ-001 Parameter KEY_WORDS, default 4, 32-bit words per cipher key (only 4 supported).
REQ-002 Parameter ROUNDS, default 10, number of cipher rounds; ROUNDS+1 round keys are stored.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 key_in  in  128  cipher key, MSB = byte 0.
REQ-006 key_valid  in  1  key_in offered.
REQ-007 key_ready  out  1  controller accepts a key this cycle.
REQ-008 busy  out  1  expansion in progress.
REQ-009 keys_valid  out  1  all ROUNDS+1 round keys stored and consistent.
REQ-010 rk_rd_en  in  1  round-key read request.
REQ-011 rk_rd_idx  in  4  round-key index to read.
REQ-012 rk_rd_data  out  128  read data, registered.
REQ-013 rk_rd_ok  out  1  rk_rd_data is valid for the previous cycle's request.

Function
REQ-014 FSM states SHALL be IDLE, EXPAND, DONE.
REQ-015 key_ready SHALL be 1 in IDLE and DONE and 0 in EXPAND.
REQ-016 A key SHALL be accepted on an edge where key_valid && key_ready; at that edge rk[0] <= key_in, the round counter <= 1, keys_valid <= 0, and state <= EXPAND.
REQ-017 In EXPAND, each edge SHALL write rk[r] = round_fn(rk[r-1], rcon[r]) and increment r; rcon = 01,02,04,08,10,20,40,80,1b,36.
REQ-018 The edge writing rk[ROUNDS] SHALL set state <= DONE and keys_valid <= 1; acceptance-to-keys_valid latency is exactly ROUNDS+1 edges (11).
REQ-019 busy SHALL equal (state == EXPAND).
REQ-020 key_valid during EXPAND SHALL be ignored; no queuing, and the current expansion is unaffected.
REQ-021 A new key accepted in DONE SHALL drop keys_valid on that same edge and restart expansion.
REQ-022 Read: on an edge where rk_rd_en=1, rk_rd_data <= rk[rk_rd_idx] and rk_rd_ok <= (rk_rd_idx <= ROUNDS) && (rk_rd_idx < r || state == DONE); otherwise rk_rd_ok <= 0.
REQ-023 An out-of-range rk_rd_idx (> ROUNDS) SHALL return rk_rd_data = 0 and rk_rd_ok = 0.
REQ-024 A read of an index written on the same edge SHALL return the old value and rk_rd_ok = 0.
REQ-025 The round counter SHALL be 4 bits wide and never exceed ROUNDS.

Reset
REQ-026 While rst_n = 0 at an edge: state = IDLE, r = 0, keys_valid = 0, busy = 0, rk_rd_ok = 0, rk_rd_data = 0; round-key storage is not cleared.
REQ-027 Reset asserted during EXPAND SHALL abort the expansion; a subsequent key restarts it from round 0.
REQ-028 key_ready SHALL be 1 on the first cycle after reset release.

Structure
REQ-029 Shared package aes_pkg SHALL hold the state enum, the rcon table, the S-box function, and the ROUNDS/KEY_WORDS defaults.
REQ-030 One combinational sub-module, aes_key_round (rotword, subword, rcon XOR, word chain), SHALL compute one round key per cycle.
REQ-031 The round-key store SHALL be an (ROUNDS+1)x128 register array with one write port and one read port.

Verification
REQ-032 Key 2b7e151628aed2a6abf7158809cf4f3c -> rk[1] = a0fafe1788542cb123a339392a6c7605 and rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6; keys_valid rises exactly 11 edges after acceptance.
REQ-033 Key 000102030405060708090a0b0c0d0e0f -> rk[10] = 13111d7fe3944a17f307a78b4d2b30c5; a read of idx 10 gives rk_rd_ok = 1 one cycle later.
REQ-034 Second key offered while busy -> key_ready = 0, the key is ignored, and the first key's rk[10] is unchanged.
REQ-035 rst_n = 0 at round 5 -> IDLE, keys_valid = 0; re-issuing key 2b7e... gives correct keys after 11 edges.
REQ-036 Read idx 11 or 15 -> rk_rd_ok = 0, rk_rd_data = 0; read idx 3 during EXPAND at r = 2 -> rk_rd_ok = 0.
REQ-037 New key accepted in DONE -> keys_valid falls on the same edge and returns to 1 after 11 edges with the new rk[10].

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: controller states, default sizes,
// round constants and the byte substitution used by the key round.
package aes_pkg;

  localparam int KEY_WORDS_DEF = 4;
  localparam int ROUNDS_DEF    = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Round constant for round 1..10; other indices never reach the XOR.
  function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as inverse (x^254, zero maps to zero) followed by the affine map,
  // which avoids carrying a 256-entry table through every subword.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = gf_mul(x, x);
    inv = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_key_round.sv
// One AES-128 key-expansion round: rotword, subword, rcon XOR and the
// four-word XOR chain, purely combinational.
module aes_key_round
  import aes_pkg::*;
(
  input  logic [127:0] prev_key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] t;
  logic [31:0] n0, n1, n2, n3;

  always_comb begin
    {w0, w1, w2, w3} = prev_key;
    // Rotate left by one byte then substitute each byte.
    t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
        ^ {rcon, 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule controller: accepts a cipher key, expands one round
// key per cycle into a register store and serves registered reads.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int KEY_WORDS = KEY_WORDS_DEF,
  parameter int ROUNDS    = ROUNDS_DEF
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [32*KEY_WORDS-1:0]   key_in,
  input  logic                      key_valid,
  output logic                      key_ready,
  output logic                      busy,
  output logic                      keys_valid,
  input  logic                      rk_rd_en,
  input  logic [3:0]                rk_rd_idx,
  output logic [32*KEY_WORDS-1:0]   rk_rd_data,
  output logic                      rk_rd_ok,
  output logic [1:0]                dbg_state
);

  localparam logic [3:0] LAST_RND = 4'(ROUNDS);

  state_t                  state, state_nxt;
  logic [3:0]              rnd;
  logic [3:0]              prev_idx;
  logic                    accept;
  logic [32*KEY_WORDS-1:0] rk_mem [0:ROUNDS];
  logic [127:0]            rk_next;

  // Key handshake: key_in is taken on any rising edge where key_valid and
  // key_ready are both high; key_valid while key_ready is low is dropped,
  // never held over, so the producer must re-offer after the expansion.
  assign accept   = key_valid && key_ready;
  assign prev_idx = (rnd == 4'd0) ? 4'd0 : rnd - 4'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_EXPAND;
      ST_EXPAND: if (rnd == LAST_RND) state_nxt = ST_DONE;
      ST_DONE:   if (accept) state_nxt = ST_EXPAND;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    key_ready = (state != ST_EXPAND);
    busy      = (state == ST_EXPAND);
    dbg_state = state;
  end

  // The counter parks at the last round once it has been written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rnd        <= 4'd0;
      keys_valid <= 1'b0;
    end else if (accept) begin
      rnd        <= 4'd1;
      keys_valid <= 1'b0;
    end else if (state == ST_EXPAND) begin
      if (rnd == LAST_RND) keys_valid <= 1'b1;
      else                 rnd        <= rnd + 4'd1;
    end
  end

  aes_key_round u_round (
    .prev_key (rk_mem[prev_idx]),
    .rcon     (rcon_of(rnd)),
    .next_key (rk_next)
  );

  // Store has no reset: contents are only trusted through rnd/state.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (accept)                  rk_mem[0]   <= key_in;
      else if (state == ST_EXPAND) rk_mem[rnd] <= rk_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rk_rd_data <= '0;
      rk_rd_ok   <= 1'b0;
    end else if (rk_rd_en) begin
      if (rk_rd_idx <= LAST_RND) begin
        rk_rd_data <= rk_mem[rk_rd_idx];
        rk_rd_ok   <= (rk_rd_idx < rnd) || (state == ST_DONE);
      end else begin
        rk_rd_data <= '0;
        rk_rd_ok   <= 1'b0;
      end
    end else begin
      rk_rd_ok <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl against a FIPS-197 style
// word-oriented key expansion model with a brute-force S-box.
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic         busy;
  logic         keys_valid;
  logic         rk_rd_en = 1'b0;
  logic [3:0]   rk_rd_idx = '0;
  logic [127:0] rk_rd_data;
  logic         rk_rd_ok;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sbox_tab [0:255];
  logic [127:0] model_rk [0:10];
  logic [127:0] old_rk   [0:10];
  logic [127:0] exp_q [$];
  logic         exp_ok_q [$];

  localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;

  aes_key_sched_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rk_rd_en   (rk_rd_en),
    .rk_rd_idx  (rk_rd_idx),
    .rk_rd_data (rk_rd_data),
    .rk_rd_ok   (rk_rd_ok),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model
  function automatic int m_mul(input int a, input int b);
    int p;
    int aa;
    int bb;
    p = 0; aa = a; bb = b;
    while (bb != 0) begin
      if ((bb & 1) != 0) p = p ^ aa;
      aa = aa << 1;
      if ((aa & 'h100) != 0) aa = aa ^ 'h11b;
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    int inv;
    int s;
    int bit_v;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (m_mul(x, y) == 1) inv = y;
      s = 0;
      for (int i = 0; i < 8; i++) begin
        bit_v = ((inv >> i) ^ (inv >> ((i + 4) % 8)) ^ (inv >> ((i + 5) % 8)) ^
                 (inv >> ((i + 6) % 8)) ^ (inv >> ((i + 7) % 8)) ^ ('h63 >> i)) & 1;
        s = s | (bit_v << i);
      end
      sbox_tab[x] = 8'(s);
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    int rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 1;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t[31:24] = t[31:24] ^ 8'(rc);
        rc = rc << 1;
        if (rc > 'hff) rc = rc ^ 'h11b;
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) begin
      old_rk[r]   = model_rk[r];
      model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic accept_key(input logic [127:0] key);
    key_in    = key;
    key_valid = 1'b1;
    n_checks++;
    if (key_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready: key_ready=%b expected 1", key_ready);
    end
    tick();
    key_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || keys_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_state: busy=%b keys_valid=%b expected 1/0", busy, keys_valid);
    end
  endtask

  task automatic wait_done(input int start, output int edges);
    edges = start;
    while (keys_valid !== 1'b1 && edges < 40) begin
      tick();
      edges++;
    end
    n_checks++;
    if (keys_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL done_timeout: keys_valid=%b after %0d edges expected 1", keys_valid, edges);
    end
  endtask

  task automatic read_rk(input logic [3:0] idx, output logic [127:0] data, output logic ok);
    rk_rd_en  = 1'b1;
    rk_rd_idx = idx;
    tick();
    rk_rd_en = 1'b0;
    data = rk_rd_data;
    ok   = rk_rd_ok;
  endtask

  task automatic check_all_rk(input string tag);
    logic [127:0] d;
    logic ok;
    for (int i = 0; i < 11; i++) begin
      read_rk(4'(i), d, ok);
      n_checks++;
      if (d !== model_rk[i] || ok !== 1'b1) begin
        n_fail++;
        $display("FAIL %s rk[%0d]: got %h ok=%b expected %h ok=1", tag, i, d, ok, model_rk[i]);
      end
    end
  endtask

  // Tests
  task automatic test_reset();
    rst_n = 1'b0;
    rk_rd_en = 1'b1;
    rk_rd_idx = 4'd0;
    key_valid = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (keys_valid !== 1'b0 || busy !== 1'b0 || rk_rd_ok !== 1'b0 || rk_rd_data !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: keys_valid=%b busy=%b rd_ok=%b rd_data=%h expected 0/0/0/0",
               keys_valid, busy, rk_rd_ok, rk_rd_data);
    end
    rst_n = 1'b1;
    rk_rd_en = 1'b0;
    tick();
    n_checks++;
    if (key_ready !== 1'b1 || busy !== 1'b0 || keys_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: key_ready=%b busy=%b keys_valid=%b expected 1/0/0",
               key_ready, busy, keys_valid);
    end
  endtask

  task automatic test_fips_vector();
    logic [127:0] d;
    logic ok;
    int edges;
    model_expand(KEY_A);
    accept_key(KEY_A);
    wait_done(1, edges);
    n_checks++;
    if (edges != 11) begin
      n_fail++;
      $display("FAIL fips_latency: edges=%0d expected 11", edges);
    end
    read_rk(4'd1, d, ok);
    n_checks++;
    if (d !== 128'ha0fafe1788542cb123a339392a6c7605 || ok !== 1'b1) begin
      n_fail++;
      $display("FAIL fips_rk1: got %h ok=%b expected a0fafe1788542cb123a339392a6c7605 ok=1", d, ok);
    end
    read_rk(4'd10, d, ok);
    n_checks++;
    if (d !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || ok !== 1'b1) begin
      n_fail++;
      $display("FAIL fips_rk10: got %h ok=%b expected d014f9a8c9ee2589e13f0cc8b6630ca6 ok=1", d, ok);
    end
    check_all_rk("fips_all");
  endtask

  task automatic test_new_key_in_done();
    logic [127:0] d;
    logic ok;
    int edges;
    model_expand(KEY_B);
    accept_key(KEY_B);
    wait_done(1, edges);
    n_checks++;
    if (edges != 11) begin
      n_fail++;
      $display("FAIL restart_latency: edges=%0d expected 11", edges);
    end
    read_rk(4'd10, d, ok);
    n_checks++;
    if (d !== 128'h13111d7fe3944a17f307a78b4d2b30c5 || ok !== 1'b1) begin
      n_fail++;
      $display("FAIL vec2_rk10: got %h ok=%b expected 13111d7fe3944a17f307a78b4d2b30c5 ok=1", d, ok);
    end
  endtask

  task automatic test_busy_ignore();
    logic [127:0] key_a;
    logic [127:0] key_b;
    logic [127:0] d;
    logic ok;
    int edges;
    key_a = {$urandom(), $urandom(), $urandom(), $urandom()};
    key_b = {$urandom(), $urandom(), $urandom(), $urandom()};
    model_expand(key_a);
    accept_key(key_a);
    key_in    = key_b;
    key_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (key_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_ready: key_ready=%b busy=%b expected 0/1", key_ready, busy);
      end
      tick();
    end
    key_valid = 1'b0;
    wait_done(6, edges);
    n_checks++;
    if (edges != 11) begin
      n_fail++;
      $display("FAIL busy_latency: edges=%0d expected 11", edges);
    end
    read_rk(4'd10, d, ok);
    n_checks++;
    if (d !== model_rk[10] || ok !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_rk10: got %h ok=%b expected %h ok=1", d, ok, model_rk[10]);
    end
  endtask

  task automatic test_read_during_expand();
    logic [127:0] d;
    logic ok;
    logic [127:0] prev3;
    int edges;
    model_expand({$urandom(), $urandom(), $urandom(), $urandom()});
    prev3 = old_rk[3];
    accept_key(model_rk[0]);
    tick();
    read_rk(4'd3, d, ok);
    n_checks++;
    if (ok !== 1'b0) begin
      n_fail++;
      $display("FAIL expand_rd_ahead: ok=%b expected 0", ok);
    end
    read_rk(4'd3, d, ok);
    n_checks++;
    if (ok !== 1'b0 || d !== prev3) begin
      n_fail++;
      $display("FAIL expand_rd_same_edge: got %h ok=%b expected %h ok=0", d, ok, prev3);
    end
    read_rk(4'd3, d, ok);
    n_checks++;
    if (ok !== 1'b1 || d !== model_rk[3]) begin
      n_fail++;
      $display("FAIL expand_rd_written: got %h ok=%b expected %h ok=1", d, ok, model_rk[3]);
    end
    wait_done(5, edges);
    n_checks++;
    if (edges != 11) begin
      n_fail++;
      $display("FAIL expand_latency: edges=%0d expected 11", edges);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] d;
    logic ok;
    int edges;
    accept_key(KEY_B);
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (keys_valid !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_state: keys_valid=%b busy=%b key_ready=%b expected 0/0/1",
               keys_valid, busy, key_ready);
    end
    read_rk(4'd0, d, ok);
    n_checks++;
    if (ok !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_rd_ok: ok=%b expected 0", ok);
    end
    model_expand(KEY_A);
    accept_key(KEY_A);
    wait_done(1, edges);
    n_checks++;
    if (edges != 11) begin
      n_fail++;
      $display("FAIL midreset_latency: edges=%0d expected 11", edges);
    end
    check_all_rk("midreset_all");
  endtask

  task automatic test_read_range();
    logic [127:0] d;
    logic ok;
    logic [3:0] bad_idx [0:1];
    bad_idx[0] = 4'd11;
    bad_idx[1] = 4'd15;
    for (int i = 0; i < 2; i++) begin
      read_rk(bad_idx[i], d, ok);
      n_checks++;
      if (ok !== 1'b0 || d !== 128'h0) begin
        n_fail++;
        $display("FAIL range_idx%0d: got %h ok=%b expected 0 ok=0", bad_idx[i], d, ok);
      end
    end
  endtask

  // Back-to-back random reads with a one-cycle expected queue.
  task automatic test_back_to_back();
    logic [127:0] e_d;
    logic e_ok;
    logic en;
    int idx;
    for (int k = 0; k < 3; k++) begin
      int edges;
      model_expand({$urandom(), $urandom(), $urandom(), $urandom()});
      accept_key(model_rk[0]);
      wait_done(1, edges);
      for (int i = 0; i < 30; i++) begin
        en  = ($urandom_range(0, 3) != 0);
        idx = $urandom_range(0, 15);
        rk_rd_en  = en;
        rk_rd_idx = 4'(idx);
        exp_q.push_back((idx <= 10) ? model_rk[idx] : 128'h0);
        exp_ok_q.push_back(en && idx <= 10);
        tick();
        e_d  = exp_q.pop_front();
        e_ok = exp_ok_q.pop_front();
        n_checks++;
        if (rk_rd_ok !== e_ok || (en && rk_rd_data !== e_d)) begin
          n_fail++;
          $display("FAIL b2b_read en=%b idx=%0d: got %h ok=%b expected %h ok=%b",
                   en, idx, rk_rd_data, rk_rd_ok, e_d, e_ok);
        end
      end
      rk_rd_en = 1'b0;
    end
  endtask

  initial begin
    build_sbox();
    for (int r = 0; r < 11; r++) model_rk[r] = '0;
    @(negedge clk);
    test_reset();
    test_fips_vector();
    test_new_key_in_done();
    test_busy_ignore();
    test_read_during_expand();
    test_reset_mid();
    test_read_range();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
